tdp_ram_be: RTL
===============

TDP_RAM_BE -- requirements
Module: tdp_ram_be

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; a multiple of BYTE_WIDTH.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, bits per byte-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9; DEPTH = 2**ADDR_WIDTH.
REQ-004 SHALL have parameters WRITE_MODE_1 and WRITE_MODE_2, default "READ_FIRST"; legal values WRITE_FIRST, READ_FIRST, NO_CHANGE.
REQ-005 SHALL have parameters OUTPUT_REG_1 and OUTPUT_REG_2, default "FALSE"; "TRUE" adds one output register stage.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default "TRUE"; enables the zero-fill sequencer.
REQ-007 SHALL have ports: clk in 1, the single clock; rst in 1, synchronous active-high reset.
REQ-008 SHALL have port-1 ports: en1 in 1 access enable; we1 in 1 write; be1 in NB byte enables; addr1 in ADDR_WIDTH; din1 in DATA_WIDTH; dout1 out DATA_WIDTH; dvalid1 out 1 read data valid.
REQ-009 SHALL have port-2 ports en2, we2, be2, addr2, din2, dout2, dvalid2, identical to port 1.
REQ-010 SHALL have ports: init_busy out 1, zero-fill in progress; collision out 1, registered same-address conflict pulse.

Function
REQ-011 An access SHALL occur on port n only when en_n=1 and init_busy=0; all other requests SHALL be ignored.
REQ-012 A write SHALL update only the byte lanes whose be bit is 1; we=1 with be=0 SHALL leave memory unchanged.
REQ-013 Read latency SHALL be 1 cycle (OUTPUT_REG "FALSE") or 2 cycles ("TRUE"); dvalid_n SHALL be high exactly in the cycle dout_n presents data.
REQ-014 READ_FIRST: dout SHALL return the pre-write word; WRITE_FIRST: dout SHALL return the post-write merged word; NO_CHANGE: a write SHALL hold dout and SHALL NOT assert dvalid.
REQ-015 Any access on a port SHALL assert dvalid, except a write in NO_CHANGE mode; en=0 SHALL hold dout and deassert dvalid.
REQ-016 Same address, both ports writing: port 1 SHALL win on lanes enabled by both; each port's exclusively enabled lanes SHALL be written.
REQ-017 Same address, one port writing, other reading: the reading port SHALL return the pre-write word.
REQ-018 collision SHALL pulse high 1 cycle after any same-address cycle with both ports accessing and at least one writing.
REQ-019 Sequencer states IDLE, CLEAR: when CLEAR_ON_RESET="TRUE", the first cycle after rst falls SHALL enter CLEAR.
REQ-020 CLEAR SHALL write zero to address 0..DEPTH-1, one per cycle, then return to IDLE; init_busy SHALL be high for exactly DEPTH cycles.
REQ-021 When CLEAR_ON_RESET="FALSE", init_busy SHALL stay 0 and memory SHALL not be cleared by reset.
REQ-022 Clear address counter SHALL be ADDR_WIDTH+1 bits; terminal count at DEPTH-1, with no wrap to a second pass.

Reset
REQ-023 While rst=1: dout1, dout2, output-stage registers, dvalid1, dvalid2 and collision SHALL be 0; sequencer SHALL be IDLE with counter 0.
REQ-024 rst asserted mid-CLEAR SHALL abort and restart the clear from address 0 after deassertion.
REQ-025 rst SHALL NOT itself alter memory contents; only the sequencer writes zeros.

Verification
REQ-026 Defaults, deassert rst -> init_busy high 512 cycles; then reads of addr 0, 511 -> 0x00000000 with dvalid1=1, 1 cycle later.
REQ-027 Write 0xAABBCCDD to addr 5, be=4'b1111; then write 0x11223344, be=4'b0101 -> read addr 5 returns 0xAA22CC44.
REQ-028 Same cycle, both ports write addr 7: port1 0x11111111 be=4'b0011, port2 0x22222222 be=4'b0110 -> word 0x00221111 (after clear); collision=1 next cycle.
REQ-029 WRITE_MODE_2=WRITE_FIRST, OUTPUT_REG_2=TRUE: port 2 writes 0x5A5A5A5A to addr 3 -> dout2=0x5A5A5A5A, dvalid2=1 exactly 2 cycles later.
REQ-030 rst pulsed at clear cycle 100 -> init_busy drops with rst, then rises again for a full 512 cycles; en1 requests during clear produce dvalid1=0.

Source files
------------

// File: rtl/tdp_ram_be.sv
// -----------------------------------------------------------------------------
// tdp_ram_be -- true dual-port RAM with per-lane byte enables, one clock.
//
// Two symmetric ports (1 and 2) each read and write one word per cycle.
// Writes touch only the byte lanes whose be bit is set. Each port has its
// own write mode: READ_FIRST, WRITE_FIRST or NO_CHANGE. Each port can add an
// optional output register stage. A zero-fill sequencer can clear the whole
// array after reset; ports are locked out while it runs.
//
// Handshake: no back-pressure. A request is taken when en_n=1 and
// init_busy=0. dvalid_n is high for exactly the one cycle in which dout_n
// carries the read data for that request. dout_n holds its value otherwise.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   en1/we1/be1/addr1/din1 -> dout1/dvalid1   port 1 request / read data
//   en2/we2/be2/addr2/din2 -> dout2/dvalid2   port 2 request / read data
//   init_busy           zero-fill in progress (ports ignored)
//   collision           one-cycle pulse after a same-address access pair
//                       in which at least one port wrote
//   seq_state           debug: sequencer state (0 = IDLE, 1 = CLEAR)
// -----------------------------------------------------------------------------
module tdp_ram_be #(
  parameter int    DATA_WIDTH     = 32,
  parameter int    BYTE_WIDTH     = 8,
  parameter int    ADDR_WIDTH     = 9,
  parameter string WRITE_MODE_1   = "READ_FIRST",
  parameter string WRITE_MODE_2   = "READ_FIRST",
  parameter string OUTPUT_REG_1   = "FALSE",
  parameter string OUTPUT_REG_2   = "FALSE",
  parameter string CLEAR_ON_RESET = "TRUE"
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en1,
  input  logic                             we1,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be1,
  input  logic [ADDR_WIDTH-1:0]            addr1,
  input  logic [DATA_WIDTH-1:0]            din1,
  output logic [DATA_WIDTH-1:0]            dout1,
  output logic                             dvalid1,
  input  logic                             en2,
  input  logic                             we2,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be2,
  input  logic [ADDR_WIDTH-1:0]            addr2,
  input  logic [DATA_WIDTH-1:0]            din2,
  output logic [DATA_WIDTH-1:0]            dout2,
  output logic                             dvalid2,
  output logic                             init_busy,
  output logic                             collision,
  output logic                             seq_state
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  localparam bit WF1     = (WRITE_MODE_1 == "WRITE_FIRST");
  localparam bit NC1     = (WRITE_MODE_1 == "NO_CHANGE");
  localparam bit WF2     = (WRITE_MODE_2 == "WRITE_FIRST");
  localparam bit NC2     = (WRITE_MODE_2 == "NO_CHANGE");
  localparam bit OREG1   = (OUTPUT_REG_1 == "TRUE");
  localparam bit OREG2   = (OUTPUT_REG_2 == "TRUE");
  localparam bit CLR_EN  = (CLEAR_ON_RESET == "TRUE");

  // ---------------------------------------------------------------------------
  // Zero-fill sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } seq_state_e;

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  // Remembers that a reset happened, so the first cycle after rst falls
  // starts the clear.
  logic                  pend_q, pend_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end
      S_CLEAR: begin
        // Counter is one bit wider than the address so it can park at DEPTH
        // after the last word instead of wrapping into a second pass.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= CLR_EN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Busy drops combinationally with rst so an aborted clear is visible at once.
  assign init_busy = (state_q == S_CLEAR) && !rst;
  assign seq_state = state_q;

  // ---------------------------------------------------------------------------
  // Access qualification and same-address detection
  // ---------------------------------------------------------------------------
  logic acc1, acc2, wr1, wr2, same;

  assign acc1 = en1 && !init_busy;
  assign acc2 = en2 && !init_busy;
  assign wr1  = acc1 && we1;
  assign wr2  = acc2 && we2;
  assign same = (addr1 == addr2);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Port 2 lanes are written first and port 1 lanes last, so on a
  // same-address double write port 1 wins the lanes both ports enable.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[cnt_q[ADDR_WIDTH-1:0]] <= '0;
    end else begin
      for (int l = 0; l < NB; l++) begin
        if (wr2 && be2[l]) mem_q[addr2][l*BYTE_WIDTH +: BYTE_WIDTH] <= din2[l*BYTE_WIDTH +: BYTE_WIDTH];
      end
      for (int l = 0; l < NB; l++) begin
        if (wr1 && be1[l]) mem_q[addr1][l*BYTE_WIDTH +: BYTE_WIDTH] <= din1[l*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Pre-write words and the post-write words a WRITE_FIRST port returns.
  // The post-write word includes the other port's lanes on a shared address.
  logic [DATA_WIDTH-1:0] old1, old2, post1, post2;

  always_comb begin
    old1  = mem_q[addr1];
    old2  = mem_q[addr2];
    post1 = old1;
    post2 = old2;
    for (int l = 0; l < NB; l++) begin
      if (same && wr2 && be2[l]) post1[l*BYTE_WIDTH +: BYTE_WIDTH] = din2[l*BYTE_WIDTH +: BYTE_WIDTH];
      if (wr1 && be1[l])         post1[l*BYTE_WIDTH +: BYTE_WIDTH] = din1[l*BYTE_WIDTH +: BYTE_WIDTH];
      if (wr2 && be2[l])         post2[l*BYTE_WIDTH +: BYTE_WIDTH] = din2[l*BYTE_WIDTH +: BYTE_WIDTH];
      if (same && wr1 && be1[l]) post2[l*BYTE_WIDTH +: BYTE_WIDTH] = din1[l*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipelines: stage 1 always, stage 2 used when OUTPUT_REG is TRUE
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd1_q, rd2_q, or1_q, or2_q;
  logic                  rv1_q, rv2_q, ov1_q, ov2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_q <= '0;
      rv1_q <= 1'b0;
      rd2_q <= '0;
      rv2_q <= 1'b0;
    end else begin
      rv1_q <= 1'b0;
      rv2_q <= 1'b0;
      // A NO_CHANGE write leaves the data register untouched and gives no
      // valid pulse.
      if (acc1 && !(wr1 && NC1)) begin
        rv1_q <= 1'b1;
        rd1_q <= (WF1 && wr1) ? post1 : old1;
      end
      if (acc2 && !(wr2 && NC2)) begin
        rv2_q <= 1'b1;
        rd2_q <= (WF2 && wr2) ? post2 : old2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      or1_q <= '0;
      ov1_q <= 1'b0;
      or2_q <= '0;
      ov2_q <= 1'b0;
    end else begin
      ov1_q <= rv1_q;
      ov2_q <= rv2_q;
      if (rv1_q) or1_q <= rd1_q;
      if (rv2_q) or2_q <= rd2_q;
    end
  end

  assign dout1   = OREG1 ? or1_q : rd1_q;
  assign dvalid1 = OREG1 ? ov1_q : rv1_q;
  assign dout2   = OREG2 ? or2_q : rd2_q;
  assign dvalid2 = OREG2 ? ov2_q : rv2_q;

  // ---------------------------------------------------------------------------
  // Collision flag
  // ---------------------------------------------------------------------------
  logic coll_q;

  always_ff @(posedge clk) begin
    if (rst) coll_q <= 1'b0;
    else     coll_q <= acc1 && acc2 && same && (we1 || we2);
  end

  assign collision = coll_q;

endmodule
